onchip_sram_dp_param: RTL and testbench
=======================================

// Module: onchip_sram_dp_param
// PURPOSE
//  Parametrised true-dual-port on-chip SRAM with two independent Avalon-MM slaves
//  (s1 = port A, s2 = port B) on one clock. Adds configurable width/depth/latency,
//  readdatavalid, deterministic same-address write arbitration, mixed-port
//  read-during-write forwarding and an optional post-reset zero-fill sequencer.
//  Drop-in store for HPS/FPGA shared buffers in the Qsys computer system.
// PARAMETERS
//  DATA_W          16   data width per port, multiple of 8
//  DEPTH           34   number of words, 2..65536
//  ADDR_W          6    address width, >= clog2(DEPTH)
//  READ_LATENCY    1    1 = unregistered q, 2 = extra output register
//  MIXED_RDW_NEW   0    0 = cross-port read during write returns old data, 1 = new data
//  CLEAR_ON_RESET  1    1 = zero-fill all words after reset, 0 = contents retained
// PORTS
//  clk               in   1         single clock for both ports
//  reset_n           in   1         synchronous, active-low reset
//  address/address2  in   ADDR_W    word address, port A / port B
//  byteenable/2      in   DATA_W/8  byte lane enables
//  chipselect/2      in   1         port request qualifier
//  write/2           in   1         1 = write, 0 = read (when chipselect)
//  clken/2           in   1         port clock enable; 0 stalls port
//  writedata/2       in   DATA_W    write data
//  readdata/2        out  DATA_W    read data
//  readdatavalid/2   out  1         1-cycle pulse, readdata valid
//  waitrequest/2     out  1         1 = request not accepted
//  clear_busy        out  1         1 while zero-fill in progress
//  collision         out  1         1-cycle pulse: same-address dual write
// BEHAVIOUR
//  - Reset (reset_n=0 at clk edge): readdata*=0, readdatavalid*=0, collision=0,
//    in-flight reads dropped; waitrequest*=clear_busy=CLEAR_ON_RESET.
//  - FSM CLEAR -> RUN. CLEAR: counter 0..DEPTH-1, writes 0 to one word per cycle,
//    waitrequest*=1; after writing word DEPTH-1, next cycle RUN. CLEAR_ON_RESET=0:
//    reset enters RUN directly, memory untouched. Reset mid-CLEAR restarts at word 0.
//  - RUN: request accepted when chipselect & clken & ~waitrequest; waitrequest*=0.
//  - Write: only lanes with byteenable=1 updated at accepting edge; no readdatavalid.
//  - Read: accepted at edge T -> readdata valid, readdatavalid=1 at T+READ_LATENCY
//    (exactly one cycle per read; back-to-back reads give one result per cycle).
//  - clken=0: no accept; READ_LATENCY=2 pipeline holds, readdata* held, valid low.
//  - Same-port read-during-write impossible (write excludes read).
//  - Cross-port: B reads address A writes same edge -> MIXED_RDW_NEW=0 old word,
//    =1 merged new word (forwarded per enabled lane); symmetric for A writing/B reading.
//  - Dual write same address same edge: port A wins on overlapping lanes, port B
//    lanes disjoint from A's are written; collision=1 next cycle.
//  - address >= DEPTH: write discarded, read returns 0 with normal readdatavalid.
//  - byteenable all-zero write: accepted, memory unchanged.
// TESTING
//  1 CLEAR_ON_RESET=1, DEPTH=34: release reset_n -> clear_busy=1 for 34 cycles, then
//    every address reads 0x0000; waitrequest=1 throughout clear.
//  2 Port A write addr 5 = 0xBEEF be=11; port B read addr 5 next cycle -> readdata2=0xBEEF,
//    readdatavalid2 at +1 (LAT=1) / +2 (LAT=2).
//  3 Same edge: A writes addr 7 = 0x1234 be=01, B writes addr 7 = 0xABCD be=11
//    -> word 7 = 0xAB34, collision pulses 1 cycle.
//  4 A writes addr 3 = 0x5555 while B reads addr 3 (old 0x0000): MIXED_RDW_NEW=0 ->
//    0x0000, =1 -> 0x5555.
//  5 Read addr 40 (DEPTH=34) -> readdata=0, valid pulse; reset_n low mid-CLEAR at word 20
//    -> clear restarts, busy lasts 34 further cycles; LAT=2 with clken low 3 cycles
//    after a read -> valid delayed 3 cycles, data correct.

Source files
------------

// File: rtl/onchip_sram_dp_param.sv
// rtl/onchip_sram_dp_param.sv - true-dual-port on-chip SRAM with two Avalon-MM slaves
// Zero-fill sequencer after reset, byte lanes, port-A-wins write arbitration, cross-port forwarding.
module onchip_sram_dp_param #(
    parameter int DATA_W         = 16,
    parameter int DEPTH          = 34,
    parameter int ADDR_W         = 6,
    parameter int READ_LATENCY   = 1,
    parameter int MIXED_RDW_NEW  = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   address,
    input  logic [ADDR_W-1:0]   address2,
    input  logic [DATA_W/8-1:0] byteenable,
    input  logic [DATA_W/8-1:0] byteenable2,
    input  logic                chipselect,
    input  logic                chipselect2,
    input  logic                write,
    input  logic                write2,
    input  logic                clken,
    input  logic                clken2,
    input  logic [DATA_W-1:0]   writedata,
    input  logic [DATA_W-1:0]   writedata2,
    output logic [DATA_W-1:0]   readdata,
    output logic [DATA_W-1:0]   readdata2,
    output logic                readdatavalid,
    output logic                readdatavalid2,
    output logic                waitrequest,
    output logic                waitrequest2,
    output logic                clear_busy,
    output logic                collision
);
    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_V   = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              busy, acc_a, acc_b, wr_a, wr_b, a_in, b_in, same_addr;
    logic [1:0]        rd_acc, ck;
    logic [DATA_W-1:0] old_a, old_b;
    logic [DATA_W-1:0] rdata [2];

    logic [1:0]        s1_v_q, out_v_q;
    logic [DATA_W-1:0] s1_d_q [2];
    logic [DATA_W-1:0] out_d_q [2];
    logic              collision_q;

    function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_w,
                                                      input logic [DATA_W-1:0] new_w,
                                                      input logic [NB-1:0]     be);
        merge_lanes = old_w;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) merge_lanes[i*8 +: 8] = new_w[i*8 +: 8];
        end
    endfunction

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_WORD) begin
                state_d   = ST_RUN;
                clr_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign busy         = (state_q == ST_CLEAR);
    assign waitrequest  = busy;
    assign waitrequest2 = busy;
    assign clear_busy   = busy;

    assign acc_a     = reset_n & ~busy & chipselect  & clken;
    assign acc_b     = reset_n & ~busy & chipselect2 & clken2;
    assign wr_a      = acc_a & write;
    assign wr_b      = acc_b & write2;
    assign rd_acc    = {acc_b & ~write2, acc_a & ~write};
    assign ck        = {clken2, clken};
    assign a_in      = {1'b0, address}  < DEPTH_V;
    assign b_in      = {1'b0, address2} < DEPTH_V;
    assign same_addr = a_in & b_in & (address == address2);

    // Port B lanes are applied first so port A's later assignment wins on overlap.
    always_ff @(posedge clk) begin
        if (reset_n && busy) begin
            mem[clr_cnt_q] <= '0;
        end else begin
            if (wr_b && b_in) begin
                for (int i = 0; i < NB; i++) begin
                    if (byteenable2[i]) mem[address2][i*8 +: 8] <= writedata2[i*8 +: 8];
                end
            end
            if (wr_a && a_in) begin
                for (int i = 0; i < NB; i++) begin
                    if (byteenable[i]) mem[address][i*8 +: 8] <= writedata[i*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        old_a    = a_in ? mem[address]  : '0;
        old_b    = b_in ? mem[address2] : '0;
        rdata[0] = old_a;
        rdata[1] = old_b;
        if (MIXED_RDW_NEW != 0 && same_addr && wr_b) rdata[0] = merge_lanes(old_a, writedata2, byteenable2);
        if (MIXED_RDW_NEW != 0 && same_addr && wr_a) rdata[1] = merge_lanes(old_b, writedata, byteenable);
    end

    // A stalled port freezes its pipeline; readdata only moves when a result is delivered.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_v_q      <= '0;
            out_v_q     <= '0;
            collision_q <= 1'b0;
            for (int p = 0; p < 2; p++) begin
                s1_d_q[p]  <= '0;
                out_d_q[p] <= '0;
            end
        end else begin
            collision_q <= wr_a & wr_b & same_addr;
            for (int p = 0; p < 2; p++) begin
                if (READ_LATENCY == 1) begin
                    out_v_q[p] <= rd_acc[p];
                    if (rd_acc[p]) out_d_q[p] <= rdata[p];
                end else if (ck[p]) begin
                    s1_v_q[p]  <= rd_acc[p];
                    if (rd_acc[p]) s1_d_q[p] <= rdata[p];
                    out_v_q[p] <= s1_v_q[p];
                    if (s1_v_q[p]) out_d_q[p] <= s1_d_q[p];
                end else begin
                    out_v_q[p] <= 1'b0;
                end
            end
        end
    end

    assign readdata       = out_d_q[0];
    assign readdata2      = out_d_q[1];
    assign readdatavalid  = out_v_q[0];
    assign readdatavalid2 = out_v_q[1];
    assign collision      = collision_q;

endmodule

// File: tb/tb_onchip_sram_dp_param.sv
// tb/tb_onchip_sram_dp_param.sv - bench for onchip_sram_dp_param
// Two instances (LAT1/old-data and LAT2/new-data) share stimulus; a word-array model predicts both.
module tb_onchip_sram_dp_param;
    localparam int DEPTH = 34;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [5:0]  a_addr, b_addr;
    logic [1:0]  a_be, b_be;
    logic        a_cs, b_cs, a_we, b_we, a_ck, b_ck;
    logic [15:0] a_wd, b_wd;

    logic [15:0] rd_o   [4];
    logic        rv_o   [4];
    logic        wait_o [4];
    logic        col_o  [2];
    logic        busy_o [2];

    onchip_sram_dp_param #(.READ_LATENCY(1), .MIXED_RDW_NEW(0)) u0 (
        .clk(clk), .reset_n(reset_n),
        .address(a_addr), .address2(b_addr), .byteenable(a_be), .byteenable2(b_be),
        .chipselect(a_cs), .chipselect2(b_cs), .write(a_we), .write2(b_we),
        .clken(a_ck), .clken2(b_ck), .writedata(a_wd), .writedata2(b_wd),
        .readdata(rd_o[0]), .readdata2(rd_o[1]), .readdatavalid(rv_o[0]), .readdatavalid2(rv_o[1]),
        .waitrequest(wait_o[0]), .waitrequest2(wait_o[1]), .clear_busy(busy_o[0]), .collision(col_o[0]));

    onchip_sram_dp_param #(.READ_LATENCY(2), .MIXED_RDW_NEW(1)) u1 (
        .clk(clk), .reset_n(reset_n),
        .address(a_addr), .address2(b_addr), .byteenable(a_be), .byteenable2(b_be),
        .chipselect(a_cs), .chipselect2(b_cs), .write(a_we), .write2(b_we),
        .clken(a_ck), .clken2(b_ck), .writedata(a_wd), .writedata2(b_wd),
        .readdata(rd_o[2]), .readdata2(rd_o[3]), .readdatavalid(rv_o[2]), .readdatavalid2(rv_o[3]),
        .waitrequest(wait_o[2]), .waitrequest2(wait_o[3]), .clear_busy(busy_o[1]), .collision(col_o[1]));

    typedef struct { int ch; int rem; logic [15:0] d; } pend_t;

    logic [15:0] ref_mem [DEPTH];
    int          clr_left;
    pend_t       pend [$];
    logic [15:0] exp_rd [4];
    logic        exp_rv [4];
    logic        exp_col;
    int          checks = 0;
    int          failures = 0;

    function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n, input logic [1:0] be);
        merge = o;
        if (be[0]) merge[7:0]  = n[7:0];
        if (be[1]) merge[15:8] = n[15:8];
    endfunction

    // Channel c = instance*2 + port; a read is due after (instance+1) enabled edges of its port.
    task automatic model_edge();
        bit busy0, acc_a, acc_b, wa, wb, ia, ib, ckp;
        logic [15:0] v;
        pend_t keep [$];
        pend_t e;
        busy0 = (clr_left > 0);
        if (!reset_n) begin
            clr_left = DEPTH;
            pend.delete();
            for (int c = 0; c < 4; c++) begin exp_rd[c] = '0; exp_rv[c] = 1'b0; end
            exp_col = 1'b0;
            return;
        end
        if (clr_left > 0) begin
            clr_left--;
            if (clr_left == 0) for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;
        end
        acc_a = !busy0 && a_cs && a_ck;
        acc_b = !busy0 && b_cs && b_ck;
        ia = (a_addr < DEPTH);
        ib = (b_addr < DEPTH);
        wa = acc_a && a_we;
        wb = acc_b && b_we;
        for (int u = 0; u < 2; u++) begin
            if (acc_a && !a_we) begin
                v = ia ? ref_mem[a_addr] : 16'h0;
                if (u == 1 && ia && wb && ib && a_addr == b_addr) v = merge(v, b_wd, b_be);
                pend.push_back('{u*2, u+1, v});
            end
            if (acc_b && !b_we) begin
                v = ib ? ref_mem[b_addr] : 16'h0;
                if (u == 1 && ib && wa && ia && a_addr == b_addr) v = merge(v, a_wd, a_be);
                pend.push_back('{u*2+1, u+1, v});
            end
        end
        exp_col = wa && wb && ia && ib && (a_addr == b_addr);
        if (wb && ib) ref_mem[b_addr] = merge(ref_mem[b_addr], b_wd, b_be);
        if (wa && ia) ref_mem[a_addr] = merge(ref_mem[a_addr], a_wd, a_be);
        for (int c = 0; c < 4; c++) exp_rv[c] = 1'b0;
        foreach (pend[j]) begin
            e = pend[j];
            ckp = (e.ch % 2 == 0) ? a_ck : b_ck;
            if (ckp) e.rem--;
            if (e.rem == 0) begin
                exp_rv[e.ch] = 1'b1;
                exp_rd[e.ch] = e.d;
            end else begin
                keep.push_back(e);
            end
        end
        pend = keep;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        a_cs = 0; b_cs = 0; a_we = 0; b_we = 0; a_ck = 1; b_ck = 1;
        a_be = 0; b_be = 0; a_addr = 0; b_addr = 0; a_wd = 0; b_wd = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle();
        repeat (3) cycle();
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (rv_o[2*u] !== 1'b0 || rv_o[2*u+1] !== 1'b0 || rd_o[2*u] !== 16'h0 || rd_o[2*u+1] !== 16'h0) begin
                failures++;
                $display("FAIL reset_read inst%0d: rv=%b%b rd=%h/%h, required rv=00 rd=0000/0000",
                         u, rv_o[2*u], rv_o[2*u+1], rd_o[2*u], rd_o[2*u+1]);
            end
            checks++;
            if (col_o[u] !== 1'b0 || busy_o[u] !== 1'b1 || wait_o[2*u] !== 1'b1 || wait_o[2*u+1] !== 1'b1) begin
                failures++;
                $display("FAIL reset_ctrl inst%0d: col=%b busy=%b wait=%b%b, required col=0 busy=1 wait=11",
                         u, col_o[u], busy_o[u], wait_o[2*u], wait_o[2*u+1]);
            end
        end
    endtask

    task automatic test_clear();
        int n = 0;
        bit wait_bad = 0;
        reset_n = 1'b1;
        do begin
            cycle();
            n++;
            if (busy_o[0] && (wait_o[0] !== 1'b1 || wait_o[1] !== 1'b1)) wait_bad = 1;
        end while (busy_o[0] === 1'b1 && n < 200);
        checks++;
        if (n != DEPTH || busy_o[1] !== 1'b0) begin
            failures++;
            $display("FAIL clear_len: busy for %0d cycles (inst1 busy=%b), required %0d and 0", n, busy_o[1], DEPTH);
        end
        checks++;
        if (wait_bad) begin
            failures++;
            $display("FAIL clear_wait: waitrequest dropped during clear, required 1");
        end
        for (int i = 0; i < DEPTH; i++) begin
            idle(); a_cs = 1; a_addr = 6'(i);
            cycle();
            checks++;
            if (rv_o[0] !== 1'b1 || rd_o[0] !== 16'h0) begin
                failures++;
                $display("FAIL clear_zero addr %0d: rv=%b rd=%h, required rv=1 rd=0000", i, rv_o[0], rd_o[0]);
            end
        end
        idle(); cycle(); cycle();
    endtask

    task automatic test_write_read();
        idle(); a_cs = 1; a_we = 1; a_addr = 5; a_wd = 16'hBEEF; a_be = 2'b11;
        cycle();
        idle(); b_cs = 1; b_addr = 5;
        cycle();
        checks++;
        if (rv_o[1] !== 1'b1 || rd_o[1] !== 16'hBEEF || rv_o[3] !== 1'b0) begin
            failures++;
            $display("FAIL wr_rd_t1: lat1 rv=%b rd=%h lat2 rv=%b, required 1 beef 0", rv_o[1], rd_o[1], rv_o[3]);
        end
        idle(); cycle();
        checks++;
        if (rv_o[1] !== 1'b0 || rv_o[3] !== 1'b1 || rd_o[3] !== 16'hBEEF) begin
            failures++;
            $display("FAIL wr_rd_t2: lat1 rv=%b lat2 rv=%b rd=%h, required 0 1 beef", rv_o[1], rv_o[3], rd_o[3]);
        end
    endtask

    task automatic test_collision();
        idle();
        a_cs = 1; a_we = 1; a_addr = 7; a_wd = 16'h1234; a_be = 2'b01;
        b_cs = 1; b_we = 1; b_addr = 7; b_wd = 16'hABCD; b_be = 2'b11;
        cycle();
        checks++;
        if (col_o[0] !== 1'b1 || col_o[1] !== 1'b1) begin
            failures++;
            $display("FAIL collision_pulse: col=%b%b, required 11", col_o[0], col_o[1]);
        end
        idle(); a_cs = 1; a_addr = 7;
        cycle();
        checks++;
        if (col_o[0] !== 1'b0 || col_o[1] !== 1'b0 || rd_o[0] !== 16'hAB34) begin
            failures++;
            $display("FAIL collision_word: col=%b%b rd=%h, required 00 ab34", col_o[0], col_o[1], rd_o[0]);
        end
        idle(); cycle();
        checks++;
        if (rv_o[2] !== 1'b1 || rd_o[2] !== 16'hAB34) begin
            failures++;
            $display("FAIL collision_word_lat2: rv=%b rd=%h, required 1 ab34", rv_o[2], rd_o[2]);
        end
    endtask

    task automatic test_mixed_rdw();
        idle();
        a_cs = 1; a_we = 1; a_addr = 3; a_wd = 16'h5555; a_be = 2'b11;
        b_cs = 1; b_addr = 3;
        cycle();
        checks++;
        if (rv_o[1] !== 1'b1 || rd_o[1] !== 16'h0000) begin
            failures++;
            $display("FAIL rdw_old: rv=%b rd=%h, required 1 0000", rv_o[1], rd_o[1]);
        end
        idle(); cycle();
        checks++;
        if (rv_o[3] !== 1'b1 || rd_o[3] !== 16'h5555) begin
            failures++;
            $display("FAIL rdw_new: rv=%b rd=%h, required 1 5555", rv_o[3], rd_o[3]);
        end
    endtask

    task automatic test_oob_and_be0();
        idle(); a_cs = 1; a_addr = 40;
        cycle();
        checks++;
        if (rv_o[0] !== 1'b1 || rd_o[0] !== 16'h0) begin
            failures++;
            $display("FAIL oob_read: rv=%b rd=%h, required 1 0000", rv_o[0], rd_o[0]);
        end
        idle(); cycle();
        checks++;
        if (rv_o[2] !== 1'b1 || rd_o[2] !== 16'h0) begin
            failures++;
            $display("FAIL oob_read_lat2: rv=%b rd=%h, required 1 0000", rv_o[2], rd_o[2]);
        end
        idle(); a_cs = 1; a_we = 1; a_addr = 5; a_wd = 16'h1111; a_be = 2'b00;
        cycle();
        idle(); a_cs = 1; a_addr = 5;
        cycle();
        checks++;
        if (rv_o[0] !== 1'b1 || rd_o[0] !== 16'hBEEF) begin
            failures++;
            $display("FAIL be_zero: rv=%b rd=%h, required 1 beef", rv_o[0], rd_o[0]);
        end
        idle(); cycle();
    endtask

    task automatic test_clken_stall();
        idle(); a_cs = 1; a_addr = 7;
        cycle();
        checks++;
        if (rv_o[0] !== 1'b1 || rd_o[0] !== 16'hAB34 || rv_o[2] !== 1'b0) begin
            failures++;
            $display("FAIL stall_issue: lat1 rv=%b rd=%h lat2 rv=%b, required 1 ab34 0", rv_o[0], rd_o[0], rv_o[2]);
        end
        for (int k = 0; k < 3; k++) begin
            idle(); a_ck = 0; a_cs = 1; a_addr = 9;
            cycle();
            checks++;
            if (rv_o[2] !== 1'b0 || rv_o[0] !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold %0d: rv lat1=%b lat2=%b, required 0 0", k, rv_o[0], rv_o[2]);
            end
        end
        idle(); cycle();
        checks++;
        if (rv_o[2] !== 1'b1 || rd_o[2] !== 16'hAB34) begin
            failures++;
            $display("FAIL stall_release: rv=%b rd=%h, required 1 ab34", rv_o[2], rd_o[2]);
        end
        cycle();
        checks++;
        if (rv_o[2] !== 1'b0) begin
            failures++;
            $display("FAIL stall_single: rv=%b, required 0", rv_o[2]);
        end
    endtask

    task automatic test_reset_mid_clear();
        int n = 0;
        idle();
        reset_n = 1'b0; cycle();
        reset_n = 1'b1;
        repeat (20) cycle();
        checks++;
        if (busy_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL mid_clear_busy: busy=%b, required 1", busy_o[0]);
        end
        reset_n = 1'b0; cycle();
        reset_n = 1'b1;
        do begin
            cycle();
            n++;
        end while (busy_o[0] === 1'b1 && n < 200);
        checks++;
        if (n != DEPTH) begin
            failures++;
            $display("FAIL mid_clear_restart: busy for %0d cycles, required %0d", n, DEPTH);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 600; t++) begin
            a_cs = ($urandom_range(0, 3) != 0);
            b_cs = ($urandom_range(0, 3) != 0);
            a_we = $urandom_range(0, 1);
            b_we = $urandom_range(0, 1);
            a_ck = ($urandom_range(0, 4) != 0);
            b_ck = ($urandom_range(0, 4) != 0);
            a_be = 2'($urandom_range(0, 3));
            b_be = 2'($urandom_range(0, 3));
            a_wd = 16'($urandom);
            b_wd = 16'($urandom);
            a_addr = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(34, 63)) : 6'($urandom_range(0, 9));
            b_addr = ($urandom_range(0, 2) == 0) ? a_addr : 6'($urandom_range(0, 9));
            cycle();
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (rv_o[c] !== exp_rv[c] || rd_o[c] !== exp_rd[c] || wait_o[c] !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_read t=%0d ch=%0d: rv=%b rd=%h wait=%b, required rv=%b rd=%h wait=0",
                             t, c, rv_o[c], rd_o[c], wait_o[c], exp_rv[c], exp_rd[c]);
                end
            end
            for (int u = 0; u < 2; u++) begin
                checks++;
                if (col_o[u] !== exp_col) begin
                    failures++;
                    $display("FAIL rand_collision t=%0d inst%0d: col=%b, required %b", t, u, col_o[u], exp_col);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_write_read();
        test_collision();
        test_mixed_rdw();
        test_oob_and_be0();
        test_clken_stall();
        test_reset_mid_clear();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
